// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a buffered auxiliary producer.
// Auxiliary results queue in a 2-entry FIFO; a starvation counter freezes the pipeline
// so the FIFO head is guaranteed to retire.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        aux_valid,
    input  logic [4:0]  aux_rd,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        stall_pipe,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    output logic        q_hit1,
    output logic        q_hit2
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      mem_q [2];
    logic        wptr_q, rptr_q;
    logic [1:0]  count_q, count_d;
    logic [3:0]  wait_q, wait_d;
    logic        rf_we_q;
    logic [4:0]  rf_rd_q;
    logic [31:0] rf_data_q;

    logic        head_valid, pipe_req, grant_pipe, grant_fifo, enq;
    logic [1:0]  slot_valid;
    entry_t      head;

    assign head_valid = (count_q != 2'd0);
    assign head       = mem_q[rptr_q];
    assign aux_ready  = rst && (count_q < 2'd2);
    assign stall_pipe = head_valid && (wait_q >= Limit);

    // Writes to x0 from the pipeline never compete for the port.
    assign pipe_req   = pipe_we && (pipe_rd != 5'd0);
    assign grant_pipe = pipe_req && !stall_pipe;
    assign grant_fifo = head_valid && !grant_pipe;
    // Aux results to x0 complete the handshake but are dropped.
    assign enq        = aux_valid && aux_ready && (aux_rd != 5'd0);

    // Next-state for occupancy and the starvation counter.
    always_comb begin
        count_d = count_q;
        unique case ({enq, grant_fifo})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        wait_d = 4'd0;
        if (head_valid && !grant_fifo) begin
            wait_d = (wait_q == 4'hF) ? 4'hF : wait_q + 4'd1;
        end
    end

    // Hazard query against every occupied FIFO slot.
    always_comb begin
        slot_valid = 2'b00;
        if (count_q == 2'd2) begin
            slot_valid = 2'b11;
        end else if (count_q == 2'd1) begin
            slot_valid[rptr_q] = 1'b1;
        end
        q_hit1 = (q_rs1 != 5'd0) &&
                 ((slot_valid[0] && (mem_q[0].rd == q_rs1)) ||
                  (slot_valid[1] && (mem_q[1].rd == q_rs1)));
        q_hit2 = (q_rs2 != 5'd0) &&
                 ((slot_valid[0] && (mem_q[0].rd == q_rs2)) ||
                  (slot_valid[1] && (mem_q[1].rd == q_rs2)));
    end

    // FIFO storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (rst && enq) begin
            mem_q[wptr_q] <= '{rd: aux_rd, data: aux_data};
        end
    end

    // Control state and the registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            count_q   <= 2'd0;
            wait_q    <= 4'd0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= 5'd0;
            rf_data_q <= 32'd0;
        end else begin
            count_q <= count_d;
            wait_q  <= wait_d;
            if (enq) begin
                wptr_q <= ~wptr_q;
            end
            if (grant_fifo) begin
                rptr_q <= ~rptr_q;
            end
            rf_we_q <= grant_pipe || grant_fifo;
            if (grant_pipe) begin
                rf_rd_q   <= pipe_rd;
                rf_data_q <= pipe_data;
            end else if (grant_fifo) begin
                rf_rd_q   <= head.rd;
                rf_data_q <= head.data;
            end
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_rd   = rf_rd_q;
    assign rf_data = rf_data_q;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback and one long-latency auxiliary producer, such as a multi-cycle mul/div unit or a late load return. The block sits between the writeback stage and the register file and registers the final write. Auxiliary results wait in a 2-entry FIFO. Pipeline writes normally take priority, and a starvation counter can freeze the pipeline so that a buffered auxiliary result is guaranteed to retire.

## Interface
Parameters:
- STARVE_LIMIT, default 4: number of consecutive cycles a buffered head may be denied before `stall_pipe` asserts. Legal range 1–15; `wait_cnt` is 4 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-low
- pipe_we  input  1  writeback stage write enable
- pipe_rd  input  5  writeback destination register
- pipe_data  input  32  writeback data
- aux_valid  input  1  auxiliary result valid
- aux_rd  input  5  auxiliary destination register
- aux_data  input  32  auxiliary result data
- aux_ready  output  1  FIFO can accept; combinational `count < 2`; forced 0 while `rst` is low
- rf_we  output  1  registered register-file write enable
- rf_rd  output  5  registered write address
- rf_data  output  32  registered write data
- stall_pipe  output  1  combinational pipeline freeze request
- q_rs1, q_rs2  input  5 each  hazard-query source registers
- q_hit1, q_hit2  output  1 each  combinational; high when the query register is nonzero and matches the `rd` of any valid FIFO entry

## Operation
- **FIFO:** 2 entries of {rd[4:0], data[31:0]}, with separate write and read pointers (1 bit each) and `count` (0–2).
- **Enqueue:** occurs on `aux_valid && aux_ready`.
  - If `aux_rd == 0`, the handshake completes but nothing is stored.
- **Full FIFO:** `aux_ready = 0`. There is no pass-through when full, even if a dequeue happens in the same cycle.
- **Grant per cycle, in priority order:**
  1. `stall_pipe` is high and FIFO is not empty → grant the FIFO head; `pipe_we` is ignored for that cycle.
  2. `pipe_we && pipe_rd != 0` → grant the pipeline.
  3. FIFO is not empty → grant the FIFO head.
  4. Otherwise → no write.
- **Pipeline writes to x0:** never granted and never block the FIFO.
- **Outputs on grant:** the granted {rd, data} is registered into `rf_rd`/`rf_data` with `rf_we = 1`. With no grant, `rf_we = 0` and `rf_rd`/`rf_data` hold their previous values.
- **Dequeue:** happens whenever the FIFO head is granted.
- **Simultaneous enqueue and dequeue** with `count == 1`: `count` stays 1 and the new entry becomes the head on the next cycle.
- **Starvation counter (`wait_cnt`):**
  - Increments, saturating at 15, on each cycle the FIFO is non-empty and the head is not dequeued.
  - Clears to 0 on a dequeue or when the FIFO is empty.
  - `stall_pipe = (count != 0) && (wait_cnt >= STARVE_LIMIT)`.
- **Pipeline contract:** while `stall_pipe` is high, the pipeline holds its writeback values and re-presents them on the next cycle. This block does not buffer pipeline writes.
- **Write ordering:**
  - Two FIFO entries with the same rd retire oldest first.
  - A pipeline write to a rd already in the FIFO retires before that FIFO entry (WAW). The hazard unit must use `q_hit*` to stall issue in this case; this block does not resolve it.
- **Reset (`rst` low at a clock edge):**
  - `rf_we = 0`, `rf_rd = 0`, `rf_data = 0`.
  - `count = 0`, pointers = 0, `wait_cnt = 0`.
  - So `stall_pipe = 0` and `q_hit* = 0`.
  - Reset in mid-operation discards buffered entries; no write is issued for them.

## Timing
- **Pipeline write:** `pipe_we` at cycle N → `rf_we` at N+1, one-cycle latency.
- **Auxiliary write:** enqueue at N → earliest grant at N+1 → `rf_we` at N+2. There is no enqueue-to-output bypass.
- **Hit outputs:** `q_hit*` reflect FIFO contents at cycle start. An entry enqueued at N is visible at N+1 and is no longer visible from the cycle after its dequeue.
- **Starvation bound:** with continuous pipeline writes, the head retires no later than STARVE_LIMIT+1 cycles after becoming head.
- **Readiness:** `aux_ready` recovers in the cycle after a dequeue from full.
- **Combinational paths:** `stall_pipe`, `aux_ready` and `q_hit*` have no path from `pipe_*` or `aux_*` inputs; they depend on registered state only, plus the `q_rs*` inputs for `q_hit*`.

## Test plan
- **Reset:** hold `rst` low for 2 cycles with all inputs active → `rf_we = 0`, `rf_rd = 0`, `rf_data = 0`, `aux_ready = 0`, `stall_pipe = 0`; after release, `aux_ready = 1`.
- **Pipeline only:** `pipe_we = 1`, `rd = 5`, `data = 0xDEADBEEF` at N → `rf_we = 1`, `rf_rd = 5`, `rf_data = 0xDEADBEEF` at N+1. With `pipe_rd = 0` → `rf_we = 0`.
- **Aux fill and drain:** send aux {7, 0x11} and then {8, 0x22} while pipeline writes every cycle, STARVE_LIMIT = 4 → `aux_ready = 0` once full. `stall_pipe` rises once `wait_cnt` reaches 4, rd 7 retires, and `wait_cnt` clears; rd 8 retires after the next starvation window. Throughout, `q_hit1 = 1` for `q_rs1 = 7` until rd 7 dequeues.
- **Idle pipeline:** enqueue {3, 0xA5} at N with `pipe_we = 0` → `rf_we`/`rf_rd = 3` at N+2, and `stall_pipe` never asserts.
- **Aux to x0 / same-rd ordering:** aux rd 0 completes its handshake with no entry and no write. Two entries to rd 9 with data 1 then 2 → `rf_data = 1`, then `rf_data = 2`.
- **Mid-operation reset:** with 2 entries buffered and `wait_cnt = 3`, pull `rst` low for 1 cycle → `count = 0`, no `rf_we` for the dropped entries, `q_hit* = 0`.
